// File: rtl/store_narrow_serializer_if.sv
// Store-path bus between the EX/MEM stage and the data-memory write port.
//   req_*     : one store request (64-bit value, byte address, size, signedness)
//   mem_*     : narrow little-endian write beats, BEAT_BYTES lanes wide
//   done      : one-cycle completion pulse
//   trunc_err : truncation status, meaningful only while done=1
// Modports:
//   master : the requester / memory model (drives req_*, mem_ready)
//   slave  : the serializer (drives req_ready, mem_* outputs, done, trunc_err)
interface store_narrow_serializer_if #(
  parameter int BEAT_BYTES = 1
);
  logic                    req_valid;
  logic                    req_ready;
  logic [63:0]             req_data;
  logic [63:0]             req_addr;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [63:0]             mem_addr;
  logic [8*BEAT_BYTES-1:0] mem_wdata;
  logic [BEAT_BYTES-1:0]   mem_be;
  logic                    mem_last;
  logic                    done;
  logic                    trunc_err;

  modport master (
    output req_valid, req_data, req_addr, req_size, req_signed, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last,
           done, trunc_err
  );

  modport slave (
    input  req_valid, req_data, req_addr, req_size, req_signed, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last,
           done, trunc_err
  );
endinterface

// File: rtl/store_narrow_serializer.sv
// store_narrow_serializer
// Narrows a 64-bit store value to 1/2/4/8 bytes, flags an invalid sign/zero
// extension in the discarded upper bits, and streams the kept bytes
// little-endian as BEAT_BYTES-wide beats on a valid/ready write port.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : store_narrow_serializer_if.slave (request side + memory beat side)
// Parameter BEAT_BYTES: bytes per memory beat, one of 1,2,4,8.
module store_narrow_serializer #(
  parameter int BEAT_BYTES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  store_narrow_serializer_if.slave    bus
);

  generate
    if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4 || BEAT_BYTES == 8)) begin : g_bad_beat_bytes
      $error("store_narrow_serializer: BEAT_BYTES must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam int BB_LOG = (BEAT_BYTES == 1) ? 0 :
                          (BEAT_BYTES == 2) ? 1 :
                          (BEAT_BYTES == 4) ? 2 : 3;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state_reg, state_next;
  logic [63:0] data_reg;
  logic [63:0] addr_reg;
  logic [1:0]  size_reg;
  logic        err_reg;
  logic [2:0]  beat_reg, beat_next;
  logic        capture;
  logic        send_active;
  logic [2:0]  last_beat;
  logic [3:0]  n_bytes;
  logic        err_calc;

  // Truncation is legal iff re-extending the kept bytes reproduces the value.
  function automatic logic ext_error(input logic [63:0] d, input logic [1:0] s,
                                     input logic sg);
    logic [63:0] ext;
    case (s)
      2'd0:    ext = sg ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      2'd1:    ext = sg ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      2'd2:    ext = sg ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      default: ext = d;
    endcase
    return ext != d;
  endfunction

  assign err_calc = ext_error(bus.req_data, bus.req_size, bus.req_signed);
  assign n_bytes  = 4'd1 << size_reg;

  // Index of the final beat: N/BEAT_BYTES - 1, or 0 when the store fits one beat.
  always_comb begin
    last_beat = 3'd0;
    if (int'(size_reg) > BB_LOG) begin
      last_beat = 3'((1 << (int'(size_reg) - BB_LOG)) - 1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      beat_reg  <= 3'd0;
      data_reg  <= 64'd0;
      addr_reg  <= 64'd0;
      size_reg  <= 2'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (capture) begin
        data_reg <= bus.req_data;
        addr_reg <= bus.req_addr;
        size_reg <= bus.req_size;
        err_reg  <= err_calc;
      end
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    capture       = 1'b0;
    send_active   = 1'b0;
    bus.req_ready = 1'b0;
    bus.done      = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          capture    = 1'b1;
          beat_next  = 3'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        send_active = 1'b1;
        if (bus.mem_ready) begin
          if (beat_reg == last_beat) begin
            state_next = DONE;
          end else begin
            beat_next = beat_reg + 3'd1;
          end
        end
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_valid = send_active;
  assign bus.mem_last  = send_active && (beat_reg == last_beat);
  assign bus.trunc_err = bus.done && err_reg;
  assign bus.mem_addr  = send_active ? (addr_reg + 64'(beat_reg) * 64'(BEAT_BYTES)) : 64'd0;

  // Per-lane byte steering. A lane is live only when the store has that many
  // bytes; short stores leave upper lanes disabled and zeroed.
  logic [BEAT_BYTES-1:0]   lane_en;
  logic [8*BEAT_BYTES-1:0] wdata_w;

  genvar gi;
  generate
    for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
      logic [2:0] byte_idx;
      assign byte_idx = 3'(int'(beat_reg) * BEAT_BYTES + gi);
      assign lane_en[gi] = send_active && (4'(gi) < n_bytes);
      assign wdata_w[8*gi +: 8] = lane_en[gi] ? data_reg[{byte_idx, 3'b000} +: 8] : 8'd0;
    end
  endgenerate

  assign bus.mem_be    = lane_en;
  assign bus.mem_wdata = wdata_w;

endmodule

// File: tb/tb_store_narrow_serializer.sv
module tb_store_narrow_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_narrow_serializer_if #(.BEAT_BYTES(1)) if1 ();
  store_narrow_serializer_if #(.BEAT_BYTES(2)) if2 ();
  store_narrow_serializer_if #(.BEAT_BYTES(4)) if4 ();

  store_narrow_serializer #(.BEAT_BYTES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  store_narrow_serializer #(.BEAT_BYTES(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  store_narrow_serializer #(.BEAT_BYTES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  // Shared request fields; valid and mem_ready steered to the selected DUT.
  int          sel = 0;
  logic        r_valid = 1'b0;
  logic [63:0] r_data = 64'd0;
  logic [63:0] r_addr = 64'd0;
  logic [1:0]  r_size = 2'd0;
  logic        r_signed = 1'b0;
  logic        m_ready = 1'b1;

  assign if1.req_valid = r_valid && (sel == 0);
  assign if2.req_valid = r_valid && (sel == 1);
  assign if4.req_valid = r_valid && (sel == 2);
  assign if1.req_data = r_data;   assign if2.req_data = r_data;   assign if4.req_data = r_data;
  assign if1.req_addr = r_addr;   assign if2.req_addr = r_addr;   assign if4.req_addr = r_addr;
  assign if1.req_size = r_size;   assign if2.req_size = r_size;   assign if4.req_size = r_size;
  assign if1.req_signed = r_signed; assign if2.req_signed = r_signed; assign if4.req_signed = r_signed;
  assign if1.mem_ready = (sel == 0) ? m_ready : 1'b1;
  assign if2.mem_ready = (sel == 1) ? m_ready : 1'b1;
  assign if4.mem_ready = (sel == 2) ? m_ready : 1'b1;

  logic        s_ready, s_valid, s_last, s_done, s_err;
  logic [63:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;

  always_comb begin
    case (sel)
      0: begin
        s_ready = if1.req_ready; s_valid = if1.mem_valid; s_addr = if1.mem_addr;
        s_wdata = {24'd0, if1.mem_wdata}; s_be = {3'd0, if1.mem_be};
        s_last = if1.mem_last; s_done = if1.done; s_err = if1.trunc_err;
      end
      1: begin
        s_ready = if2.req_ready; s_valid = if2.mem_valid; s_addr = if2.mem_addr;
        s_wdata = {16'd0, if2.mem_wdata}; s_be = {2'd0, if2.mem_be};
        s_last = if2.mem_last; s_done = if2.done; s_err = if2.trunc_err;
      end
      default: begin
        s_ready = if4.req_ready; s_valid = if4.mem_valid; s_addr = if4.mem_addr;
        s_wdata = if4.mem_wdata; s_be = if4.mem_be;
        s_last = if4.mem_last; s_done = if4.done; s_err = if4.trunc_err;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          sel;        // 0: 1-byte beats, 1: 2-byte, 2: 4-byte
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] data;
    logic [63:0] addr;
    int          beats;      // hand-computed beat count
    logic        err;        // hand-computed trunc_err
    logic [31:0] w0;         // hand-computed first-beat data
    logic [3:0]  be0;        // hand-computed first-beat enables
    int          stall_beat; // beat held with mem_ready=0 for 3 cycles, -1 none
  } vec_t;

  vec_t vecs[9];

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(if1.req_ready && if2.req_ready && if4.req_ready) && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy expected ready");
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int bb, n;
    logic [31:0] ew;
    logic [3:0]  ebe;
    logic [63:0] ea;
    logic [7:0]  bytev;
    sel = v.sel;
    bb = 1 << v.sel;
    n = 1 << v.size;
    m_ready = 1'b1;
    wait_idle();
    chk("req_ready_idle", s_ready, 1'b1);
    r_data = v.data; r_addr = v.addr; r_size = v.size; r_signed = v.sgn;
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    // Mid-transfer request changes must not affect the stored beats.
    r_data = ~v.data; r_addr = 64'h1234; r_size = ~v.size; r_signed = ~v.sgn;
    chk("req_ready_send", s_ready, 1'b0);
    for (int b = 0; b < v.beats; b++) begin
      ew = 32'd0; ebe = 4'd0;
      for (int k = 0; k < bb; k++) begin
        if (k < n) begin
          bytev = 8'(v.data >> ((b * bb + k) * 8));
          ew[8*k +: 8] = bytev;
          ebe[k] = 1'b1;
        end
      end
      ea = v.addr + 64'(b * bb);
      if (b == 0) begin
        chk("w0_table", s_wdata, v.w0);
        chk("be0_table", s_be, v.be0);
      end
      chk("mem_valid", s_valid, 1'b1);
      chk("mem_addr", s_addr, ea);
      chk("mem_wdata", s_wdata, ew);
      chk("mem_be", s_be, ebe);
      chk("mem_last", s_last, (b == v.beats - 1) ? 1'b1 : 1'b0);
      if (b == v.stall_beat) begin
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          r_valid = 1'b1;
          step();
          r_valid = 1'b0;
          chk("stall_valid", s_valid, 1'b1);
          chk("stall_addr", s_addr, ea);
          chk("stall_wdata", s_wdata, ew);
          chk("stall_last", s_last, (b == v.beats - 1) ? 1'b1 : 1'b0);
          chk("stall_done", s_done, 1'b0);
        end
        m_ready = 1'b1;
      end
      step();
    end
    chk("done_pulse", s_done, 1'b1);
    chk("trunc_err", s_err, v.err);
    chk("done_mem_valid", s_valid, 1'b0);
    chk("done_req_ready", s_ready, 1'b0);
    step();
    chk("done_clear", s_done, 1'b0);
    chk("back_idle", s_ready, 1'b1);
    $display("vec %0d: sel=%0d size=%0d data=%h beats=%0d err=%0b", id, v.sel, v.size, v.data, v.beats, v.err);
  endtask

  initial begin
    vecs[0] = '{0, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 64'h40,   1, 1'b0, 32'h80,       4'h1, -1};
    vecs[1] = '{0, 2'd1, 1'b0, 64'h0000_0000_0001_1234, 64'h100,  2, 1'b1, 32'h34,       4'h1, -1};
    vecs[2] = '{1, 2'd3, 1'b0, 64'h0102_0304_0506_0708, 64'h2000, 4, 1'b0, 32'h0708,     4'h3, -1};
    vecs[3] = '{2, 2'd0, 1'b0, 64'h0000_0000_0000_007F, 64'h30,   1, 1'b0, 32'h0000007F, 4'h1, -1};
    vecs[4] = '{0, 2'd2, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'h10,   4, 1'b0, 32'h01,       4'h1, 1};
    vecs[5] = '{2, 2'd1, 1'b1, 64'h0000_0000_0000_8000, 64'h80,   1, 1'b1, 32'h00008000, 4'h3, -1};
    vecs[6] = '{1, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFE, 2, 1'b0, 32'hBEEF, 4'h3, -1};
    vecs[7] = '{2, 2'd3, 1'b1, 64'h8000_0000_0000_0000, 64'h200,  2, 1'b0, 32'h0,        4'hF, -1};
    vecs[8] = '{1, 2'd0, 1'b0, 64'h0000_0000_0000_01FF, 64'h7,    1, 1'b1, 32'h00FF,     4'h1, -1};

    // Reset state of every instance.
    step(); step();
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #0;
      chk("rst_req_ready", s_ready, 1'b1);
      chk("rst_mem_valid", s_valid, 1'b0);
      chk("rst_mem_last", s_last, 1'b0);
      chk("rst_mem_be", s_be, 4'd0);
      chk("rst_mem_wdata", s_wdata, 32'd0);
      chk("rst_mem_addr", s_addr, 64'd0);
      chk("rst_done", s_done, 1'b0);
      chk("rst_trunc_err", s_err, 1'b0);
    end
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset asserted during beat 2 of an 8-byte store on 1-byte beats.
    sel = 0;
    m_ready = 1'b1;
    wait_idle();
    r_data = 64'h1122_3344_5566_7788; r_addr = 64'h500; r_size = 2'd3; r_signed = 1'b0;
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    step(); step();
    chk("pre_rst_addr", s_addr, 64'h502);
    chk("pre_rst_wdata", s_wdata, 32'h66);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_valid", s_valid, 1'b0);
    chk("abort_mem_addr", s_addr, 64'd0);
    chk("abort_mem_wdata", s_wdata, 32'd0);
    chk("abort_mem_be", s_be, 4'd0);
    chk("abort_req_ready", s_ready, 1'b1);
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_done", s_done, 1'b0);
      chk("abort_idle_valid", s_valid, 1'b0);
      step();
    end
    $display("reset abort: mid-transfer reset applied and released");
    run_vec(vecs[2], 100);
    run_vec(vecs[0], 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
